// File: rtl/shift_slt_alu.sv
// Registered 16-bit execute-stage slice: log barrel shifter (shift/rotate, both
// directions) plus signed/unsigned set-less-than. Bit 0 is the MSB everywhere.
module shift_slt_alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [0:15] a,
  input  logic [0:15] b,
  input  logic [0:5]  opcode,
  output logic [0:15] result,
  output logic        invalid_op
);

  localparam logic [0:1] MODE_PASS  = 2'b00;
  localparam logic [0:1] MODE_ARITH = 2'b10;
  localparam logic [0:1] MODE_ROT   = 2'b11;

  logic [0:15] result_q, result_d;
  logic        invalid_q, invalid_d;

  // Opcode field decode
  logic       dir_right;
  logic [0:1] mode;
  logic [0:3] sh;

  assign dir_right = opcode[1];
  assign mode      = opcode[4:5];
  assign sh        = a[12:15];

  function automatic logic [0:15] bit_rev(input logic [0:15] v);
    logic [0:15] r;
    for (int i = 0; i < 16; i++) begin
      r[i] = v[15-i];
    end
    return r;
  endfunction

  // Right shifts run through the left datapath on a bit-reversed operand, so
  // the arithmetic fill (b[0]) lands in the vacated high-numbered positions.
  logic        fill_bit;
  logic        rotate;
  logic [0:15] stage_v [0:4];
  logic [0:15] shift_out;

  assign fill_bit   = dir_right && (mode == MODE_ARITH) ? b[0] : 1'b0;
  assign rotate     = (mode == MODE_ROT);
  assign stage_v[0] = dir_right ? bit_rev(b) : b;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_barrel
      localparam int K = 1 << gi;
      logic [0:15] shifted;
      assign shifted = rotate ? {stage_v[gi][K:15], stage_v[gi][0:K-1]}
                              : {stage_v[gi][K:15], {K{fill_bit}}};
      assign stage_v[gi+1] = sh[3-gi] ? shifted : stage_v[gi];
    end
  endgenerate

  assign shift_out = dir_right ? bit_rev(stage_v[4]) : stage_v[4];

  // One 17-bit subtract serves both compares: bit 0 is the borrow.
  logic [0:16] diff;
  logic        overflow;
  logic        slt_bit;
  logic        sltu_bit;
  logic        unused_diff_bits;

  assign diff             = {1'b0, a} - {1'b0, b};
  assign overflow         = (a[0] != b[0]) && (diff[1] != a[0]);
  assign slt_bit          = diff[1] ^ overflow;
  assign sltu_bit         = diff[0];
  assign unused_diff_bits = ^diff[2:16];

  always_comb begin
    result_d  = 16'h0000;
    invalid_d = 1'b0;
    if (!opcode[0]) begin
      if (opcode[2:3] == 2'b00) begin
        result_d = (mode == MODE_PASS) ? b : shift_out;
      end else begin
        invalid_d = 1'b1;
      end
    end else if (opcode[1:5] == 5'b00000) begin
      result_d = {15'b0, slt_bit};
    end else if (opcode[1:5] == 5'b00001) begin
      result_d = {15'b0, sltu_bit};
    end else begin
      invalid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q  <= 16'h0000;
      invalid_q <= 1'b0;
    end else begin
      result_q  <= result_d;
      invalid_q <= invalid_d;
    end
  end

  assign result     = result_q;
  assign invalid_op = invalid_q;

endmodule

// File: tb/tb_shift_slt_alu.sv
// Directed-vector bench for shift_slt_alu; one task per feature, inline checks.
module tb_shift_slt_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [0:15] a;
  logic [0:15] b;
  logic [0:5]  opcode;
  logic [0:15] result;
  logic        invalid_op;

  int errors = 0;
  int checks = 0;

  shift_slt_alu dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a          (a),
    .b          (b),
    .opcode     (opcode),
    .result     (result),
    .invalid_op (invalid_op)
  );

  always #5 clk = ~clk;

  // Drive one transaction between edges, then sample just after the edge.
  task automatic step(input logic [0:15] av, input logic [0:15] bv, input logic [0:5] op);
    @(negedge clk);
    a = av;
    b = bv;
    opcode = op;
    @(posedge clk);
    #1;
    $display("rst_n=%b op=%b a=%h b=%h -> result=%h invalid_op=%b",
             rst_n, op, av, bv, result, invalid_op);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(16'hFFFF, 16'hFFFF, 6'b100000);
    checks++;
    if (result !== 16'h0000 || invalid_op !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold result=%h inv=%b expected 0000/0", result, invalid_op);
    end
    rst_n = 1'b1;
    step(16'hFFFF, 16'h0001, 6'b100000);
    checks++;
    if (result !== 16'h0001 || invalid_op !== 1'b0) begin
      errors++;
      $display("FAIL reset_release result=%h inv=%b expected 0001/0", result, invalid_op);
    end
    step(16'h0001, 16'hDCF1, 6'b100001);
    checks++;
    if (result !== 16'h0001) begin
      errors++;
      $display("FAIL pre_midreset result=%h expected 0001", result);
    end
    rst_n = 1'b0;
    step(16'h0001, 16'hDCF1, 6'b001001);
    checks++;
    if (result !== 16'h0000 || invalid_op !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset result=%h inv=%b expected 0000/0", result, invalid_op);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_compare();
    logic [0:15] va [0:5];
    logic [0:15] vb [0:5];
    logic [0:5]  vo [0:5];
    logic [0:15] ve [0:5];
    va = '{16'hDCF0, 16'hDCF1, 16'h1234, 16'hDCF1, 16'h0001, 16'h7FFF};
    vb = '{16'hDCF1, 16'h0001, 16'h1234, 16'h0001, 16'hDCF1, 16'h8000};
    vo = '{6'b100000, 6'b100000, 6'b100000, 6'b100001, 6'b100001, 6'b100000};
    ve = '{16'h0001, 16'h0001, 16'h0000, 16'h0000, 16'h0001, 16'h0000};
    for (int i = 0; i < 6; i++) begin
      step(va[i], vb[i], vo[i]);
      checks++;
      if (result !== ve[i] || invalid_op !== 1'b0) begin
        errors++;
        $display("FAIL compare[%0d] result=%h inv=%b expected %h/0", i, result, invalid_op, ve[i]);
      end
    end
    step(16'h1234, 16'h1234, 6'b100001);
    checks++;
    if (result !== 16'h0000) begin
      errors++;
      $display("FAIL sltu_equal result=%h expected 0000", result);
    end
  endtask

  task automatic test_shift();
    logic [0:15] va [0:14];
    logic [0:15] vb [0:14];
    logic [0:5]  vo [0:14];
    logic [0:15] ve [0:14];
    va = '{16'h0001, 16'h0001, 16'h000F, 16'h0004, 16'h0004, 16'h0004, 16'h0004,
           16'hFFF0, 16'hFFF0, 16'hFFF0, 16'h000F, 16'h000F, 16'h0007, 16'h0007,
           16'h000F};
    vb = '{16'hDCF1, 16'hDCF1, 16'hDCF1, 16'hDCF1, 16'hDCF1, 16'hDCF1, 16'hDCF1,
           16'hDCF1, 16'hDCF1, 16'hDCF1, 16'h8000, 16'h8000, 16'hDCF1, 16'hDCF1,
           16'h8001};
    vo = '{6'b000011, 6'b010011, 6'b000011, 6'b000001, 6'b010001, 6'b010010, 6'b000010,
           6'b000001, 6'b010010, 6'b010011, 6'b010010, 6'b010001, 6'b000000, 6'b010000,
           6'b000010};
    ve = '{16'hB9E3, 16'hEE78, 16'hEE78, 16'hCF10, 16'h0DCF, 16'hFDCF, 16'hCF10,
           16'hDCF1, 16'hDCF1, 16'hDCF1, 16'hFFFF, 16'h0001, 16'hDCF1, 16'hDCF1,
           16'h8000};
    for (int i = 0; i < 15; i++) begin
      step(va[i], vb[i], vo[i]);
      checks++;
      if (result !== ve[i] || invalid_op !== 1'b0) begin
        errors++;
        $display("FAIL shift[%0d] op=%b result=%h inv=%b expected %h/0",
                 i, vo[i], result, invalid_op, ve[i]);
      end
    end
  endtask

  task automatic test_invalid();
    logic [0:5] vo [0:3];
    vo = '{6'b001001, 6'b110000, 6'b100010, 6'b000100};
    for (int i = 0; i < 4; i++) begin
      step(16'h0001, 16'hDCF1, vo[i]);
      checks++;
      if (result !== 16'h0000 || invalid_op !== 1'b1) begin
        errors++;
        $display("FAIL invalid[%0d] op=%b result=%h inv=%b expected 0000/1",
                 i, vo[i], result, invalid_op);
      end
    end
  endtask

  task automatic test_back_to_back();
    step(16'h0001, 16'hDCF1, 6'b110000);
    step(16'h0001, 16'hDCF1, 6'b100001);
    checks++;
    if (result !== 16'h0001 || invalid_op !== 1'b0) begin
      errors++;
      $display("FAIL valid_after_invalid result=%h inv=%b expected 0001/0", result, invalid_op);
    end
    // Inputs moving between edges must not disturb the registered outputs.
    #2;
    a = 16'h0004;
    b = 16'h8000;
    opcode = 6'b001001;
    #1;
    checks++;
    if (result !== 16'h0001 || invalid_op !== 1'b0) begin
      errors++;
      $display("FAIL hold_between_edges result=%h inv=%b expected 0001/0", result, invalid_op);
    end
    step(16'h0004, 16'hDCF1, 6'b000001);
    checks++;
    if (result !== 16'hCF10) begin
      errors++;
      $display("FAIL b2b_shift result=%h expected cf10", result);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a = 16'h0000;
    b = 16'h0000;
    opcode = 6'b000000;
    test_reset();
    test_compare();
    test_shift();
    test_invalid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
